// File: rtl/mcu_dispatcher_if.sv
// Pixel-stream and DCT-lane bundle between the MCU dispatcher and its lanes.
// master = dispatcher side; `DISPATCH_STALL_CNT_EN adds stall_cycles.
interface mcu_dispatcher_if #(
  parameter int NUM_LANES = 8,
  parameter int PIX_W     = 8,
  parameter int DC_W      = 14
);
  logic [PIX_W-1:0]          pix_in;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [PIX_W-1:0]          lane_pix;
  logic [NUM_LANES-1:0]      lane_en;
  logic [NUM_LANES-1:0]      lane_start;
  logic [NUM_LANES-1:0]      lane_first;
  logic [NUM_LANES*DC_W-1:0] lane_dc_in;
  logic [NUM_LANES*DC_W-1:0] lane_dc_out;
  logic [NUM_LANES-1:0]      lane_valid;
  logic [NUM_LANES-1:0]      lane_done;
  logic                      frame_done;

`ifdef DISPATCH_STALL_CNT_EN
  logic [15:0]               stall_cycles;

  modport master (
    input  pix_in, pix_valid, lane_dc_out, lane_valid, lane_done,
    output pix_ready, lane_pix, lane_en, lane_start, lane_first, lane_dc_in, frame_done, stall_cycles
  );
  modport slave (
    output pix_in, pix_valid, lane_dc_out, lane_valid, lane_done,
    input  pix_ready, lane_pix, lane_en, lane_start, lane_first, lane_dc_in, frame_done, stall_cycles
  );
`else
  modport master (
    input  pix_in, pix_valid, lane_dc_out, lane_valid, lane_done,
    output pix_ready, lane_pix, lane_en, lane_start, lane_first, lane_dc_in, frame_done
  );
  modport slave (
    output pix_in, pix_valid, lane_dc_out, lane_valid, lane_done,
    input  pix_ready, lane_pix, lane_en, lane_start, lane_first, lane_dc_in, frame_done
  );
`endif
endinterface

// File: rtl/mcu_dispatcher.sv
// Slices a raster pixel stream into MCU blocks, deals them round-robin to DCT lanes and chains DC predictors.
// Pixel reaches lanes 1 cycle after accept; pix_ready drops while the target lane is busy. `DISPATCH_STALL_CNT_EN adds stall_cycles.
module mcu_dispatcher #(
  parameter int NUM_LANES  = 8,
  parameter int PIX_W      = 8,
  parameter int DC_W       = 14,
  parameter int MCU_PIX    = 64,
  parameter int FRAME_MCUS = 8
) (
  input logic              clk,
  input logic              rst,
  mcu_dispatcher_if.master bus
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int CW = (MCU_PIX > 1) ? $clog2(MCU_PIX) : 1;
  localparam int MW = (FRAME_MCUS > 1) ? $clog2(FRAME_MCUS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  state_t                    state_q, state_d;
  logic [LW-1:0]             lane_idx_q, lane_idx_d;
  logic [CW-1:0]             pix_cnt_q, pix_cnt_d;
  logic [MW-1:0]             mcu_cnt_q, mcu_cnt_d;
  logic [NUM_LANES-1:0]      busy_q, busy_d;
  logic [NUM_LANES-1:0]      first_q, first_d;
  logic [NUM_LANES-1:0]      last_q, last_d;
  logic [NUM_LANES-1:0]      vld_prev_q, vld_prev_d;
  logic [NUM_LANES-1:0]      en_q, en_d;
  logic [NUM_LANES-1:0]      start_q, start_d;
  logic [PIX_W-1:0]          pix_q, pix_d;
  logic [NUM_LANES*DC_W-1:0] dc_q, dc_d;
  logic                      frame_end_q, frame_end_d;
  logic                      frame_done_q, frame_done_d;

  logic                      ready;
  logic                      accept;
  logic                      mcu_start;
  logic                      mcu_end;
  logic                      lane_free;
  logic [NUM_LANES-1:0]      vld_rise;

  // A lane finishing in the same cycle it is needed again may be reused at once.
  assign lane_free = !busy_q[lane_idx_q] || bus.lane_done[lane_idx_q];
  assign ready     = rst && ((state_q == STREAM) || lane_free);
  assign accept    = bus.pix_valid && ready;
  assign mcu_start = accept && (state_q != STREAM);
  assign mcu_end   = accept && (state_q == STREAM) && (pix_cnt_q == CW'(MCU_PIX - 1));
  assign vld_rise  = bus.lane_valid & ~vld_prev_q;

  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    pix_cnt_d    = pix_cnt_q;
    mcu_cnt_d    = mcu_cnt_q;
    busy_d       = busy_q & ~bus.lane_done;
    first_d      = first_q;
    last_d       = last_q;
    vld_prev_d   = bus.lane_valid;
    en_d         = '0;
    start_d      = '0;
    pix_d        = pix_q;
    dc_d         = dc_q;
    frame_end_d  = 1'b0;
    frame_done_d = frame_end_q;

    case (state_q)
      IDLE, WAIT: begin
        if (mcu_start)      state_d = STREAM;
        else if (lane_free) state_d = IDLE;
        else                state_d = WAIT;
      end
      STREAM:  if (mcu_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      pix_d              = bus.pix_in;
      en_d[lane_idx_q]   = 1'b1;
      pix_cnt_d          = pix_cnt_q + CW'(1);
    end

    if (mcu_start) begin
      start_d[lane_idx_q] = 1'b1;
      busy_d[lane_idx_q]  = 1'b1;
      first_d[lane_idx_q] = (mcu_cnt_q == '0);
      last_d[lane_idx_q]  = (mcu_cnt_q == MW'(FRAME_MCUS - 1));
    end

    if (mcu_end) begin
      pix_cnt_d  = '0;
      lane_idx_d = (lane_idx_q == LW'(NUM_LANES - 1)) ? '0 : lane_idx_q + LW'(1);
      if (mcu_cnt_q == MW'(FRAME_MCUS - 1)) begin
        mcu_cnt_d   = '0;
        frame_end_d = 1'b1;
      end else begin
        mcu_cnt_d   = mcu_cnt_q + MW'(1);
      end
    end

    // The successor's first flag is checked after this cycle's start so a lane just leaving a frame-first MCU can accept.
    for (int p = 0; p < NUM_LANES; p++) begin
      if (vld_rise[p] && !last_q[p] && !first_d[(p + 1) % NUM_LANES])
        dc_d[((p + 1) % NUM_LANES) * DC_W +: DC_W] = bus.lane_dc_out[p * DC_W +: DC_W];
    end
    if (mcu_start && (mcu_cnt_q == '0))
      dc_d[lane_idx_q * DC_W +: DC_W] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lane_idx_q   <= '0;
      pix_cnt_q    <= '0;
      mcu_cnt_q    <= '0;
      busy_q       <= '0;
      first_q      <= '0;
      last_q       <= '0;
      vld_prev_q   <= '0;
      en_q         <= '0;
      start_q      <= '0;
      pix_q        <= '0;
      dc_q         <= '0;
      frame_end_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      mcu_cnt_q    <= mcu_cnt_d;
      busy_q       <= busy_d;
      first_q      <= first_d;
      last_q       <= last_d;
      vld_prev_q   <= vld_prev_d;
      en_q         <= en_d;
      start_q      <= start_d;
      pix_q        <= pix_d;
      dc_q         <= dc_d;
      frame_end_q  <= frame_end_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = ready;
  assign bus.lane_pix   = pix_q;
  assign bus.lane_en    = en_q;
  assign bus.lane_start = start_q;
  assign bus.lane_first = first_q;
  assign bus.lane_dc_in = dc_q;
  assign bus.frame_done = frame_done_q;

`ifdef DISPATCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.pix_valid && !ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
    if (mcu_start && (mcu_cnt_q == '0))
      stall_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mcu_dispatcher.sv
// Scoreboard bench for mcu_dispatcher: 4 lanes, 16-pixel MCUs, 6-MCU frames, with a behavioural lane engine.
// Expected lane traffic is queued at accept time and popped when the dispatcher presents it.
module tb_mcu_dispatcher;
  localparam int NL = 4;
  localparam int PW = 8;
  localparam int DW = 14;
  localparam int MP = 16;
  localparam int FM = 6;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mcu_dispatcher_if #(.NUM_LANES(NL), .PIX_W(PW), .DC_W(DW)) bus ();

  mcu_dispatcher #(
    .NUM_LANES(NL), .PIX_W(PW), .DC_W(DW), .MCU_PIX(MP), .FRAME_MCUS(FM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    logic [PW-1:0] pix;
    logic          start;
  } exp_t;

  exp_t            sb[$];
  int              m_idx, m_cnt, m_mcu, m_stall;
  logic [NL-1:0]   m_busy, m_first, m_last, m_vprev;
  logic [NL*DW-1:0] m_dc;
  logic            m_fend, m_fdone;
  int              eng_t[NL];
  int              hold[NL];
  int              eng_lat;
  logic            force37, sent37, chk37, want_rst_first;
  logic            acc_i;
  int              bud;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_cnt = 0; m_mcu = 0; m_stall = 0;
    m_busy = '0; m_first = '0; m_last = '0; m_vprev = '0; m_dc = '0;
    m_fend = 1'b0; m_fdone = 1'b0;
    sb.delete();
    for (int k = 0; k < NL; k++) begin
      eng_t[k] = 0;
      hold[k]  = 0;
    end
    bus.pix_valid = 1'b0; bus.pix_in = '0;
    bus.lane_valid = '0; bus.lane_done = '0; bus.lane_dc_out = '0;
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_ready"},  64'(bus.pix_ready),  64'd0);
    check({pre, "_pix"},    64'(bus.lane_pix),   64'd0);
    check({pre, "_en"},     64'(bus.lane_en),    64'd0);
    check({pre, "_start"},  64'(bus.lane_start), 64'd0);
    check({pre, "_first"},  64'(bus.lane_first), 64'd0);
    check({pre, "_dc"},     64'(bus.lane_dc_in), 64'd0);
    check({pre, "_fdone"},  64'(bus.frame_done), 64'd0);
  endtask

  task automatic check_outputs();
    exp_t          e;
    logic [NL-1:0] en_exp, st_exp;
    en_exp = '0;
    st_exp = '0;
    if (sb.size() > 0) begin
      if (want_rst_first) begin
        check("rst_start0", 64'(bus.lane_start[0]), 64'd1);
        check("rst_first0", 64'(bus.lane_first[0]), 64'd1);
        want_rst_first = 1'b0;
      end
      e = sb.pop_front();
      en_exp[e.lane] = 1'b1;
      st_exp[e.lane] = e.start;
      check("lane_pix", 64'(bus.lane_pix), 64'(e.pix));
    end
    if (chk37) begin
      check("dc37", 64'(bus.lane_dc_in[DW +: DW]), 64'd37);
      chk37 = 1'b0;
    end
    check("lane_en",    64'(bus.lane_en),    64'(en_exp));
    check("lane_start", 64'(bus.lane_start), 64'(st_exp));
    check("lane_first", 64'(bus.lane_first), 64'(m_first));
    check("lane_dc_in", 64'(bus.lane_dc_in), 64'(m_dc));
    check("frame_done", 64'(bus.frame_done), 64'(m_fdone));
`ifdef DISPATCH_STALL_CNT_EN
    check("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
`endif
  endtask

  // One clock: check last edge's outputs, drive lanes and pixel, predict the coming edge.
  task automatic cycle(input logic want_vld, input logic [PW-1:0] pix, output logic acc);
    logic [NL-1:0] done_now, rise, old_last;
    logic          rdy_exp, start;
    int            succ;
    @(negedge clk);
    check_outputs();
    done_now = '0;
    for (int k = 0; k < NL; k++) begin
      if (eng_t[k] > 0) begin
        eng_t[k]--;
        if (eng_t[k] == 3) begin
          bus.lane_valid[k] = 1'b1;
          if (k == 0 && force37) begin
            bus.lane_dc_out[k*DW +: DW] = 14'd37;
            force37 = 1'b0;
            sent37  = 1'b1;
          end else begin
            bus.lane_dc_out[k*DW +: DW] = DW'($urandom);
          end
        end
        if (eng_t[k] == 0) begin
          done_now[k]       = 1'b1;
          bus.lane_valid[k] = 1'b0;
        end
      end
    end
    bus.lane_done = done_now;
    bus.pix_valid = want_vld;
    bus.pix_in    = pix;
    #1;
    rdy_exp = (m_cnt != 0) || !m_busy[m_idx] || done_now[m_idx];
    check("pix_ready", 64'(bus.pix_ready), 64'(rdy_exp));
    acc = want_vld && rdy_exp;

    rise    = bus.lane_valid & ~m_vprev;
    m_vprev = bus.lane_valid;
    if (want_vld && !rdy_exp && m_stall < 65535) m_stall++;
    m_fdone  = m_fend;
    m_fend   = 1'b0;
    start    = acc && (m_cnt == 0);
    old_last = m_last;
    m_busy   = m_busy & ~done_now;
    if (start) begin
      m_busy[m_idx]  = 1'b1;
      m_first[m_idx] = (m_mcu == 0);
      m_last[m_idx]  = (m_mcu == FM - 1);
      if (m_mcu == 0) m_stall = 0;
      eng_t[m_idx] = eng_lat + hold[m_idx];
      hold[m_idx]  = 0;
    end
    for (int p = 0; p < NL; p++) begin
      succ = (p + 1) % NL;
      if (rise[p] && !old_last[p] && !m_first[succ]) begin
        m_dc[succ*DW +: DW] = bus.lane_dc_out[p*DW +: DW];
        if (p == 0 && sent37) chk37 = 1'b1;
      end
      if (rise[p] && p == 0) sent37 = 1'b0;
    end
    if (start && m_mcu == 0) m_dc[m_idx*DW +: DW] = '0;
    if (acc) begin
      sb.push_back('{lane: m_idx, pix: pix, start: start});
      m_cnt++;
      if (m_cnt == MP) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % NL;
        if (m_mcu == FM - 1) begin
          m_mcu  = 0;
          m_fend = 1'b1;
        end else begin
          m_mcu++;
        end
      end
    end
  endtask

  task automatic run(input int npix, input int pct, input int budget);
    int   got, cyc;
    logic acc, v;
    got = 0;
    cyc = 0;
    while (got < npix && cyc < budget) begin
      v = ($urandom_range(99) < 32'(pct));
      cycle(v, PW'($urandom), acc);
      if (acc) got++;
      cyc++;
    end
    if (got < npix) check("run_timeout", 64'(got), 64'(npix));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
  endtask

  initial begin
    rst = 1'b1;
    force37 = 1'b0; sent37 = 1'b0; chk37 = 1'b0; want_rst_first = 1'b0;
    eng_lat = MP + 4;
    model_reset();
    #2 rst = 1'b0;
    #1 check_zero("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    force37 = 1'b1;
    run(2 * FM * MP, 100, 400);        // continuous, lanes answer promptly
    run(FM * MP, 50, 800);             // gappy valid mid-MCU
    hold[0] = 100;
    run(FM * MP, 100, 800);            // lane 0 done withheld
    eng_lat = 70;
    run(FM * MP + MP, 100, 1500);      // every wrap waits for done, done+start same cycle
    eng_lat = MP + 4;
    idle(80);

    bud = 0;
    while (m_cnt != 10 && bud < 200) begin
      cycle(1'b1, PW'($urandom), acc_i);
      bud++;
    end
    check("reach_mid_mcu", 64'(m_cnt), 64'd10);
    @(negedge clk);
    check_outputs();
    #2 rst = 1'b0;
    #1 check_zero("mid_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    want_rst_first = 1'b1;
    run(FM * MP, 100, 400);
    idle(120);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("rst_first_seen", 64'(want_rst_first), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
